// File: rtl/rx_pixel_sink.sv
// rx_pixel_sink: captures the horizontal-sync pixel stream into frame-buffer writes, tracks row/column,
//   flags short/long lines and reports line and frame completion.
// Latency: one cycle from the sampling edge to wr_en/wr_addr/wr_data and to the line pulses.
// Backpressure: none; the frame-buffer port must accept one write per cycle.
//
// Optional feature macro: RX_BMP_FLIP_EN
//   Defined: rows are stored bottom-up (BMP order).
//   Undefined: rows are stored top-down.
//
// Ports:
//   horizontal_clock   rising-edge clock
//   horizontal_reset   asynchronous, active-low reset
//   horizontal_sync    high = r/g/b carry a pixel, low = blanking
//   r, g, b            8-bit pixel components
//   wr_en/wr_addr/wr_data  frame-buffer write port, data = {r,g,b}
//   line_done          one-cycle pulse per closed line
//   frame_done         sticky, set when the last line closes
//   line_error         one-cycle pulse on a short or long line
//   error_seen         sticky OR of line_error
//   row, column        current line index and pixels accepted in it
module rx_pixel_sink #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 19
) (
  input  logic              horizontal_clock,
  input  logic              horizontal_reset,
  input  logic              horizontal_sync,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              line_done,
  output logic              frame_done,
  output logic              line_error,
  output logic              error_seen,
  output logic [9:0]        row,
  output logic [9:0]        column
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, DONE} state_t;

  localparam logic [9:0] WIDTH_C  = 10'(WIDTH);
  localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);
  localparam logic [9:0] LAST_ROW = 10'(HEIGHT - 1);

  state_t              state_q, state_d;
  logic [9:0]          row_q, row_d;
  logic [9:0]          column_q, column_d;
  // Set once the current line has dropped a pixel, so the long-line error fires only once.
  logic                long_q, long_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [23:0]         wr_data_q, wr_data_d;
  logic                line_done_q, line_done_d;
  logic                frame_done_q, frame_done_d;
  logic                line_error_q, line_error_d;
  logic                error_seen_q, error_seen_d;

  logic                accept;
  logic                fall_close;
  logic [ADDR_W-1:0]   row_term;
  logic [ADDR_W-1:0]   pix_addr;

  always_comb begin
`ifdef RX_BMP_FLIP_EN
    row_term = ADDR_W'(HEIGHT - 1) - ADDR_W'(row_q);
`else
    row_term = ADDR_W'(row_q);
`endif
    pix_addr = row_term * ADDR_W'(WIDTH) + ADDR_W'(column_q);
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    column_d     = column_q;
    long_d       = long_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    line_done_d  = 1'b0;
    line_error_d = 1'b0;
    frame_done_d = frame_done_q;
    accept       = 1'b0;
    fall_close   = 1'b0;

    case (state_q)
      IDLE, BLANK: begin
        // The sample that opens a line is itself a pixel.
        if (horizontal_sync) begin
          state_d = ACTIVE;
          accept  = (column_q < WIDTH_C);
        end
      end
      ACTIVE: begin
        if (horizontal_sync) begin
          if (column_q < WIDTH_C) begin
            accept = 1'b1;
          end else begin
            // Long line: drop the pixel, report only the first drop.
            line_error_d = ~long_q;
            long_d       = 1'b1;
          end
        end else begin
          fall_close = 1'b1;
        end
      end
      default: ;
    endcase

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_addr_d = pix_addr;
      wr_data_d = {r, g, b};
      column_d  = column_q + 10'd1;
      // The last line closes on its final pixel without waiting for sync to fall.
      if (row_q == LAST_ROW && column_q == LAST_COL) begin
        line_done_d  = 1'b1;
        frame_done_d = 1'b1;
        state_d      = DONE;
      end
    end

    if (fall_close) begin
      line_done_d  = 1'b1;
      line_error_d = (column_q < WIDTH_C);
      column_d     = 10'd0;
      long_d       = 1'b0;
      if (row_q == LAST_ROW) begin
        frame_done_d = 1'b1;
        state_d      = DONE;
      end else begin
        row_d   = row_q + 10'd1;
        state_d = BLANK;
      end
    end

    error_seen_d = error_seen_q | line_error_d;
  end

  always_ff @(posedge horizontal_clock or negedge horizontal_reset) begin
    if (!horizontal_reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      column_q     <= '0;
      long_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      line_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      line_error_q <= 1'b0;
      error_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      column_q     <= column_d;
      long_q       <= long_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      line_done_q  <= line_done_d;
      frame_done_q <= frame_done_d;
      line_error_q <= line_error_d;
      error_seen_q <= error_seen_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign line_done  = line_done_q;
  assign frame_done = frame_done_q;
  assign line_error = line_error_q;
  assign error_seen = error_seen_q;
  assign row        = row_q;
  assign column     = column_q;

endmodule

// File: doc/rx_pixel_sink.md
# rx_pixel_sink

Receiving end of the horizontal-sync pixel stream produced by the team's image source. It samples r/g/b while `horizontal_sync` is high and tracks row and column. Each accepted pixel becomes one 24-bit write to an external frame-buffer port. The block flags line-length errors and reports per-line and per-frame completion, so the resize pipeline and testbench can capture a full 768×512 frame.

## Interface
- `WIDTH`, 768, active pixels per line.
- `HEIGHT`, 512, lines per frame.
- `ADDR_W`, 19, frame-buffer word-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.

- `horizontal_clock`  in  1  clock; all logic on the rising edge.
- `horizontal_reset`  in  1  reset, asynchronous, active-low.
- `horizontal_sync`  in  1  high = r/g/b carry a valid pixel this cycle; low = blanking.
- `r`, `g`, `b`  in  8 each  pixel components.
- `wr_en`  out  1  frame-buffer write strobe, one cycle per accepted pixel.
- `wr_addr`  out  ADDR_W  word address of the write.
- `wr_data`  out  24  {r,g,b}, with r in [23:16].
- `line_done`  out  1  one-cycle pulse when a line closes, whether complete or short.
- `frame_done`  out  1  level; high once HEIGHT lines have closed. Sticky until reset.
- `line_error`  out  1  one-cycle pulse on a short or long line.
- `error_seen`  out  1  sticky OR of every `line_error` since reset.
- `row`  out  10  current line index, 0..HEIGHT-1.
- `column`  out  10  pixels accepted in the current line, 0..WIDTH.

## Operation
- States:
  - IDLE: waiting for the first sampled `horizontal_sync`=1; the IDLE→ACTIVE sample itself is accepted.
  - ACTIVE: sync high, capturing.
  - BLANK: sync low between lines.
  - DONE.
- Transitions:
  - IDLE→ACTIVE on sync=1.
  - ACTIVE→BLANK on sync=0.
  - BLANK→ACTIVE on sync=1.
  - Any state→DONE when the line that closes is line HEIGHT-1.
  - DONE holds until reset and ignores all input.
- Accepting a pixel (ACTIVE or the entering sample, sync=1, `column`<WIDTH):
  - issue a write;
  - `column`+1.
- Long line: `column`==WIDTH and sync=1.
  - The pixel is dropped, with no write.
  - `line_error` pulses once on the first dropped pixel of that line only.
- Line close on sync falling (ACTIVE→BLANK):
  - `line_done` pulses.
  - If `column`<WIDTH, `line_error` also pulses (short line).
  - `column`←0 and `row`+1.
  - A short line still consumes a row; its missing pixels are not written.
- The last line closes on `column` reaching WIDTH while `row`==HEIGHT-1; the block does not wait for sync to fall.
- Address: `wr_addr` = row_term*WIDTH + `column`, computed at ADDR_W width; no wrap is possible within legal parameters. `row_term` depends on `RX_BMP_FLIP_EN` (see Configuration).
- Simultaneous long-line drop and close: the close takes effect. Both pulses may be high in the same cycle.

## Timing
- Inputs are registered once. `wr_en`/`wr_addr`/`wr_data` are valid the cycle after the edge that sampled sync=1, giving one cycle of latency.
- Back-to-back pixels give back-to-back writes with no bubbles.
- `line_done` and short-line `line_error` assert the cycle after the edge that sampled sync=0.
- `frame_done` rises in the same cycle as the final `wr_en`.
- Reset:
  - All outputs are 0 and the state is IDLE.
  - `row` = `column` = 0 and `error_seen` = 0.
- Reset asserted mid-frame clears everything immediately, with no partial-line pulses. After release, capture restarts at row 0 on the next sync=1.
- Minimum blanking is 1 cycle. A source that keeps sync high permanently produces a single long line.

## Configuration
- `RX_BMP_FLIP_EN` defined: row_term = HEIGHT-1-`row`. Rows are stored bottom-up (BMP order), so line 0 lands at address (HEIGHT-1)*WIDTH.
- `RX_BMP_FLIP_EN` undefined: row_term = `row`. Top-down order; line 0 lands at address 0.
- No other behaviour differs.

## Test plan
- Full frame: 512 lines × 768 pixels with 160-cycle blanking, pixel = {row[7:0], col[7:0], 8'hA5}, macro defined.
  - Required: exactly 393216 writes.
  - Line 0 pixel 0 is at address 392448 with data {8'h00, 8'h00, 8'hA5}.
  - Last write is at address 767.
  - `frame_done`=1 on the last write; `error_seen`=0.
- Same frame with the macro undefined: line 0 pixel 0 at address 0; line 511 pixel 767 at address 393215.
- Short line: line 3 sync drops after 700 pixels.
  - Required: one `line_error` and one `line_done`; `row`→4; 700 writes for that line.
  - Line 4 starts at `column` 0; `error_seen`=1.
- Long line: line 0 holds sync for 770 cycles.
  - Required: 768 writes and a single `line_error` on pixel 769.
  - `line_done` on sync fall; `row`=1.
- Reset mid-frame: assert reset during line 10, pixel 400.
  - Required: all outputs 0 immediately.
  - After release, the next line is written at row 0.
- After `frame_done`, drive another 768-pixel line: required no `wr_en`, no pulses, `frame_done` stays 1.
